// File: rtl/xram_resp_pkg.sv
// xram_resp shared definitions: FSM state encoding, port IDs, default sizing.
package xram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_ACC = 1'b1;

  localparam int DEF_MEM_DEPTH   = 4096;
  localparam int DEF_WAIT_CYCLES = 2;

  // True when a 16-bit byte address falls inside the backing array.
  function automatic logic addr_in_range(input logic [15:0] addr, input int depth);
    return int'({16'h0000, addr}) < depth;
  endfunction

endpackage

// File: rtl/xram_byte_mem.sv
// Single-port DEPTH x 8 byte array: synchronous write, registered read.
// Contents are intentionally not reset.
module xram_byte_mem
  import xram_resp_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write on enable; read data always registered from the current address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/xram_resp.sv
// xram_resp: two-port (CPU / accelerator) byte-RAM responder with round-robin
// arbitration and WAIT_CYCLES wait states between grant and ack.
// Optional feature: define XRAM_RESP_STATS_EN to get saturating per-port
// completed-transaction counters; otherwise the counter outputs are tied to 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction; arbitrate between the strobes
// ST_WAIT | granted; counting down wait states, abort if stb drops
// ST_ACK  | one-cycle ack to granted port; write commits at cycle end
module xram_resp
  import xram_resp_pkg::*;
#(
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  input  logic        cpu_wr,
  input  logic        cpu_stb,
  output logic        cpu_ack,
  input  logic [15:0] acc_addr,
  input  logic [7:0]  acc_data_in,
  output logic [7:0]  acc_data_out,
  input  logic        acc_wr,
  input  logic        acc_stb,
  output logic        acc_ack,
  output logic [15:0] cpu_xact_cnt,
  output logic [15:0] acc_xact_cnt
);

  localparam int         AW      = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          last_grant;
  logic          grant_port;
  logic [AW-1:0] addr_l;
  logic          wr_l;
  logic [7:0]    data_l;
  logic          in_range_l;

  logic          winner;
  logic [15:0]   win_addr;
  logic          win_wr;
  logic [7:0]    win_data;
  logic          granted_stb;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          rd_ok;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    if (cpu_stb && acc_stb) winner = ~last_grant;
    else if (acc_stb)       winner = PORT_ACC;
    else                    winner = PORT_CPU;
    win_addr    = (winner == PORT_ACC) ? acc_addr    : cpu_addr;
    win_wr      = (winner == PORT_ACC) ? acc_wr      : cpu_wr;
    win_data    = (winner == PORT_ACC) ? acc_data_in : cpu_data_in;
    granted_stb = (grant_port == PORT_ACC) ? acc_stb : cpu_stb;
  end

  // The array is read on the cycle before ACK. With zero wait states that
  // cycle is IDLE itself, so the incoming winner address goes straight in.
  assign mem_addr = (state == ST_IDLE) ? win_addr[AW-1:0] : addr_l;
  assign mem_we   = (state == ST_ACK) && wr_l && in_range_l && rst;

  xram_byte_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (data_l),
    .rdata (mem_rdata)
  );

  // Request sequencing: grant, wait states, single-cycle ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      last_grant <= PORT_CPU;
      grant_port <= PORT_CPU;
      addr_l     <= '0;
      wr_l       <= 1'b0;
      data_l     <= 8'h00;
      in_range_l <= 1'b0;
      cpu_ack    <= 1'b0;
      acc_ack    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_stb || acc_stb) begin
            grant_port <= winner;
            last_grant <= winner;
            addr_l     <= win_addr[AW-1:0];
            wr_l       <= win_wr;
            data_l     <= win_data;
            in_range_l <= addr_in_range(win_addr, MEM_DEPTH);
            wait_cnt   <= WAIT_LD;
            if (WAIT_CYCLES == 0) begin
              state   <= ST_ACK;
              cpu_ack <= (winner == PORT_CPU);
              acc_ack <= (winner == PORT_ACC);
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!granted_stb) begin
            state <= ST_IDLE;
          end else if (wait_cnt <= 4'd1) begin
            state    <= ST_ACK;
            wait_cnt <= 4'd0;
            cpu_ack  <= (grant_port == PORT_CPU);
            acc_ack  <= (grant_port == PORT_ACC);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          state   <= ST_IDLE;
          cpu_ack <= 1'b0;
          acc_ack <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data only reaches the acked port, and only for in-range reads.
  assign rd_ok        = !wr_l && in_range_l;
  assign cpu_data_out = (cpu_ack && rd_ok) ? mem_rdata : 8'h00;
  assign acc_data_out = (acc_ack && rd_ok) ? mem_rdata : 8'h00;

`ifdef XRAM_RESP_STATS_EN
  logic [15:0] cpu_cnt_q;
  logic [15:0] acc_cnt_q;

  // Saturating count of acked transactions per port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_cnt_q <= 16'h0000;
      acc_cnt_q <= 16'h0000;
    end else begin
      if (cpu_ack && (cpu_cnt_q != 16'hFFFF)) cpu_cnt_q <= cpu_cnt_q + 16'd1;
      if (acc_ack && (acc_cnt_q != 16'hFFFF)) acc_cnt_q <= acc_cnt_q + 16'd1;
    end
  end

  assign cpu_xact_cnt = cpu_cnt_q;
  assign acc_xact_cnt = acc_cnt_q;
`else
  assign cpu_xact_cnt = 16'h0000;
  assign acc_xact_cnt = 16'h0000;
`endif

endmodule
